// File: rtl/apb_filter_cfg_regs.sv
// APB configuration registers for the address filter: NUM_REGIONS START/END/CTRL windows,
// programmable wait states, sticky per-region write lock and slave error responses.
module apb_filter_cfg_regs #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PADDR_WIDTH = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                              pclock,
    input  logic                              presetn,
    input  logic                              psel,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [PADDR_WIDTH-1:0]            paddr,
    input  logic [DATA_WIDTH-1:0]             pwdata,
    output logic [DATA_WIDTH-1:0]             prdata,
    output logic                              pready,
    output logic                              pslverr,
    output logic [NUM_REGIONS*ADDR_WIDTH-1:0] start_addr,
    output logic [NUM_REGIONS*ADDR_WIDTH-1:0] end_addr,
    output logic [NUM_REGIONS*2-1:0]          ctrl_reg,
    output logic [NUM_REGIONS-1:0]            region_cfg_done,
    output logic                              config_b
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    localparam logic [1:0] LP_WAIT = 2'(WAIT_STATES);

    state_t                  r_state;
    logic [1:0]              r_wait_cnt;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [ADDR_WIDTH-1:0]   r_start [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]   r_end   [NUM_REGIONS];
    logic [NUM_REGIONS-1:0]  r_en;
    logic [NUM_REGIONS-1:0]  r_xor;
    logic [NUM_REGIONS-1:0]  r_lock;
    logic [NUM_REGIONS-1:0]  r_wr_start;
    logic [NUM_REGIONS-1:0]  r_wr_end;
    logic [NUM_REGIONS-1:0]  r_wr_ctrl;

    logic [3:0]              w_idx;
    logic [1:0]              w_off;
    logic                    w_aligned;
    logic                    w_hi_zero;
    logic                    w_region_ok;
    logic                    w_is_status;
    logic                    w_is_param;
    logic                    w_locked;
    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_sel_start;
    logic [ADDR_WIDTH-1:0]   w_sel_end;
    logic [2:0]              w_sel_ctrl;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Address decode and error classification for the current bus address.
    always_comb begin
        w_idx       = paddr[7:4];
        w_off       = paddr[3:2];
        w_aligned   = (paddr[1:0] == 2'b00);
        w_hi_zero   = ((paddr >> 9) == {PADDR_WIDTH{1'b0}});
        w_region_ok = w_hi_zero && !paddr[8] && (32'(w_idx) < NUM_REGIONS) && (w_off != 2'b11);
        w_is_status = w_hi_zero && (paddr[8:0] == 9'h100);
        w_is_param  = w_hi_zero && (paddr[8:0] == 9'h104);
        w_err       = !w_aligned
                    || !(w_region_ok || w_is_status || w_is_param)
                    || (pwrite && (w_is_status || w_is_param))
                    || (pwrite && w_region_ok && w_locked);
    end

    // Select the addressed region's fields without indexing past the array.
    always_comb begin
        w_sel_start = '0;
        w_sel_end   = '0;
        w_sel_ctrl  = 3'b000;
        w_locked    = 1'b0;
        for (int n = 0; n < NUM_REGIONS; n++) begin
            w_sel_start = (w_idx == 4'(n)) ? r_start[n] : w_sel_start;
            w_sel_end   = (w_idx == 4'(n)) ? r_end[n] : w_sel_end;
            w_sel_ctrl  = (w_idx == 4'(n)) ? {r_lock[n], r_xor[n], r_en[n]} : w_sel_ctrl;
            w_locked    = (w_idx == 4'(n)) ? r_lock[n] : w_locked;
        end
    end

    // Read data mux; zero for writes and erroring accesses.
    always_comb begin
        w_rdata = '0;
        if (!w_err && !pwrite) begin
            if (w_is_status) begin
                w_rdata[NUM_REGIONS-1:0]  = region_cfg_done;
                w_rdata[8 +: NUM_REGIONS] = r_lock;
            end else if (w_is_param) begin
                w_rdata[3:0] = 4'(NUM_REGIONS);
                w_rdata[7:4] = 4'(WAIT_STATES);
            end else begin
                case (w_off)
                    2'b00:   w_rdata[ADDR_WIDTH-1:0] = w_sel_start;
                    2'b01:   w_rdata[ADDR_WIDTH-1:0] = w_sel_end;
                    2'b10:   w_rdata[2:0]            = w_sel_ctrl;
                    default: w_rdata                 = '0;
                endcase
            end
        end else begin
            w_rdata = '0;
        end
    end

    // Transfer FSM, response registers and register-file commit.
    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 2'd0;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_en       <= '0;
            r_xor      <= '0;
            r_lock     <= '0;
            r_wr_start <= '0;
            r_wr_end   <= '0;
            r_wr_ctrl  <= '0;
            for (int n = 0; n < NUM_REGIONS; n++) begin
                r_start[n] <= '0;
                r_end[n]   <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    if (psel && !penable) begin
                        r_state    <= ST_ACCESS;
                        r_wait_cnt <= LP_WAIT;
                        if (LP_WAIT == 2'd0) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= w_rdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        // Aborted transfer: drop back without touching registers.
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= 2'd0;
                        r_pready   <= 1'b0;
                        r_pslverr  <= 1'b0;
                        r_prdata   <= '0;
                    end else if (r_pready) begin
                        if (penable) begin
                            r_state   <= ST_IDLE;
                            r_pready  <= 1'b0;
                            r_pslverr <= 1'b0;
                            r_prdata  <= '0;
                            for (int n = 0; n < NUM_REGIONS; n++) begin
                                if (pwrite && !w_err && (w_idx == 4'(n))) begin
                                    case (w_off)
                                        2'b00: begin
                                            r_start[n]    <= pwdata[ADDR_WIDTH-1:0];
                                            r_wr_start[n] <= 1'b1;
                                        end
                                        2'b01: begin
                                            r_end[n]    <= pwdata[ADDR_WIDTH-1:0];
                                            r_wr_end[n] <= 1'b1;
                                        end
                                        2'b10: begin
                                            r_en[n]      <= pwdata[0];
                                            r_xor[n]     <= pwdata[1];
                                            r_lock[n]    <= r_lock[n] | pwdata[2];
                                            r_wr_ctrl[n] <= 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end else if (r_wait_cnt != 2'd0) begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                        if (r_wait_cnt == 2'd1) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= w_rdata;
                        end
                    end else begin
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= w_rdata;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_out
        assign start_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_start[g];
        assign end_addr[g*ADDR_WIDTH +: ADDR_WIDTH]   = r_end[g];
        assign ctrl_reg[2*g +: 2]                     = {r_xor[g], r_en[g]};
    end

    assign region_cfg_done = r_wr_start & r_wr_end & r_wr_ctrl;
    assign config_b        = &region_cfg_done;
    assign prdata          = r_prdata;
    assign pready          = r_pready;
    assign pslverr         = r_pslverr;

endmodule

// File: tb/tb_apb_filter_cfg_regs.sv
// Scoreboard bench for apb_filter_cfg_regs: expected APB responses are queued at stimulus
// time and compared when pready rises; register outputs are checked against a bench model.
module tb_apb_filter_cfg_regs;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 12;
    localparam int WS = 2;

    logic                pclock  = 1'b0;
    logic                presetn = 1'b0;
    logic                psel    = 1'b0;
    logic                penable = 1'b0;
    logic                pwrite  = 1'b0;
    logic [PW-1:0]       paddr   = '0;
    logic [DW-1:0]       pwdata  = '0;
    logic [DW-1:0]       prdata;
    logic                pready;
    logic                pslverr;
    logic [NR*AW-1:0]    start_addr;
    logic [NR*AW-1:0]    end_addr;
    logic [NR*2-1:0]     ctrl_reg;
    logic [NR-1:0]       region_cfg_done;
    logic                config_b;

    apb_filter_cfg_regs #(
        .NUM_REGIONS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PW), .WAIT_STATES(WS)
    ) dut (
        .pclock(pclock), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .start_addr(start_addr), .end_addr(end_addr), .ctrl_reg(ctrl_reg),
        .region_cfg_done(region_cfg_done), .config_b(config_b)
    );

    always #5 pclock = ~pclock;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;

    logic [31:0] m_start [NR];
    logic [31:0] m_end   [NR];
    logic [2:0]  m_ctrl  [NR];
    logic [NR-1:0] m_ws, m_we, m_wc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NR; n++) begin
            m_start[n] = '0;
            m_end[n]   = '0;
            m_ctrl[n]  = '0;
        end
        m_ws = '0;
        m_we = '0;
        m_wc = '0;
    endtask

    task automatic model_resp(input logic wr, input logic [11:0] a,
                              output logic err, output logic [31:0] rd);
        int idx;
        err = 1'b0;
        rd  = '0;
        idx = int'(a[7:4]);
        if (a[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (a[11:8] == 4'h0) begin
            if (idx >= NR || a[3:0] == 4'hC) err = 1'b1;
            else if (wr && m_ctrl[idx][2]) err = 1'b1;
            else if (!wr && a[3:0] == 4'h0) rd = m_start[idx];
            else if (!wr && a[3:0] == 4'h4) rd = m_end[idx];
            else if (!wr) rd = {29'd0, m_ctrl[idx]};
        end else if (a == 12'h100) begin
            if (wr) err = 1'b1;
            else begin
                rd[NR-1:0] = m_ws & m_we & m_wc;
                for (int n = 0; n < NR; n++) rd[8+n] = m_ctrl[n][2];
            end
        end else if (a == 12'h104) begin
            if (wr) err = 1'b1;
            else rd = 32'h0000_0024;
        end else begin
            err = 1'b1;
        end
    endtask

    task automatic model_commit(input logic [11:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a[7:4]);
        case (a[3:0])
            4'h0: begin m_start[idx] = d; m_ws[idx] = 1'b1; end
            4'h4: begin m_end[idx] = d; m_we[idx] = 1'b1; end
            4'h8: begin m_ctrl[idx] = {m_ctrl[idx][2] | d[2], d[1:0]}; m_wc[idx] = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        logic [NR*AW-1:0] es, ee;
        logic [NR*2-1:0]  ec;
        logic [NR-1:0]    ed;
        for (int n = 0; n < NR; n++) begin
            es[n*AW +: AW] = m_start[n];
            ee[n*AW +: AW] = m_end[n];
            ec[2*n +: 2]   = m_ctrl[n][1:0];
        end
        ed = m_ws & m_we & m_wc;
        check({tag, "/start_addr"}, start_addr, es);
        check({tag, "/end_addr"}, end_addr, ee);
        check({tag, "/ctrl_reg"}, ctrl_reg, ec);
        check({tag, "/cfg_done"}, region_cfg_done, ed);
        check({tag, "/config_b"}, config_b, &ed);
    endtask

    // Full transfer; caller is positioned just after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d);
        logic        err;
        logic [31:0] rd;
        logic        seen;
        int          waits;
        model_resp(wr, a, err, rd);
        exp_q.push_back('{rd: rd, err: err});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclock); #1;
        penable = 1'b1;
        seen  = 1'b0;
        waits = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge pclock);
            if (pready) seen = 1'b1;
            else waits++;
        end
        check("pready_seen", seen, 1'b1);
        check("wait_cycles", waits, WS);
        check_outputs("pre_commit");
        @(posedge pclock); #1;
        if (wr && !err) model_commit(a, d);
        psel = 1'b0; penable = 1'b0;
        check_outputs("post_commit");
    endtask

    // Response scoreboard: pop on each pready cycle, idle outputs must be zero.
    always @(negedge pclock) begin
        resp_t e;
        if (presetn && pready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pready", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("prdata", prdata, e.rd);
                check("pslverr", pslverr, e.err);
            end
        end else if (presetn) begin
            check("idle_prdata", prdata, 32'd0);
            check("idle_pslverr", pslverr, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge pclock);
        @(negedge pclock);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check_outputs("reset");
        @(posedge pclock); #1;
        presetn = 1'b1;
        @(posedge pclock); #1;

        apb_xfer(1'b0, 12'h104, 32'd0);

        apb_xfer(1'b1, 12'h010, 32'h0000_1000);
        apb_xfer(1'b1, 12'h014, 32'h0000_1FFF);
        apb_xfer(1'b1, 12'h018, 32'h0000_0003);
        check("r1_start", start_addr[63:32], 32'h0000_1000);
        check("r1_end", end_addr[63:32], 32'h0000_1FFF);
        check("r1_ctrl", ctrl_reg[3:2], 2'b11);
        check("r1_done", region_cfg_done, 4'b0010);
        check("r1_config_b", config_b, 1'b0);
        apb_xfer(1'b0, 12'h010, 32'd0);
        apb_xfer(1'b0, 12'h014, 32'd0);
        apb_xfer(1'b0, 12'h018, 32'd0);

        for (int r = 0; r < NR; r++) begin
            if (r != 1) begin
                apb_xfer(1'b1, 12'(r * 16),     32'h0001_0000 * (r + 1));
                apb_xfer(1'b1, 12'(r * 16 + 4), 32'h0001_FFFF * (r + 1));
                apb_xfer(1'b1, 12'(r * 16 + 8), 32'(r % 2 + 1));
            end
        end
        check("all_config_b", config_b, 1'b1);
        apb_xfer(1'b0, 12'h100, 32'd0);

        apb_xfer(1'b1, 12'h008, 32'h0000_0005);
        apb_xfer(1'b1, 12'h000, 32'h0000_ABCD);
        check("locked_start", start_addr[31:0], 32'h0001_0000);
        check("lock_ctrl", ctrl_reg[1:0], 2'b01);
        apb_xfer(1'b0, 12'h100, 32'd0);

        apb_xfer(1'b0, 12'h042, 32'd0);
        apb_xfer(1'b1, 12'h042, 32'h1234_5678);
        apb_xfer(1'b0, 12'h040, 32'd0);
        apb_xfer(1'b1, 12'h040, 32'h1234_5678);
        apb_xfer(1'b1, 12'h100, 32'hFFFF_FFFF);
        apb_xfer(1'b1, 12'h104, 32'hFFFF_FFFF);
        apb_xfer(1'b0, 12'h01C, 32'd0);
        apb_xfer(1'b0, 12'h200, 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 4) * 16 + $urandom_range(0, 3) * 4);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            apb_xfer(1'($urandom_range(0, 1)), a, $urandom);
        end

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h55;
        @(posedge pclock); #1;
        penable = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        model_reset();
        check("midrst_pready", pready, 1'b0);
        check("midrst_prdata", prdata, 32'd0);
        check("midrst_pslverr", pslverr, 1'b0);
        check_outputs("midrst");
        @(posedge pclock); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclock); #1;
        presetn = 1'b1;
        @(posedge pclock); #1;
        apb_xfer(1'b0, 12'h010, 32'd0);

        repeat (2) @(posedge pclock);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/apb_filter_cfg_regs.md
Name: apb_filter_cfg_regs

Overview:
Parametrised APB configuration register block for the address filter. It holds NUM_REGIONS independent filter windows, each with START, END and CTRL registers. The block adds programmable wait states, a per-region write lock, and full error signalling on the slave response. It sits between the APB bus and the filter datapath and drives the per-region window bounds, region controls and configuration-done flags.

Parameters:
NUM_REGIONS, 4, number of filter windows (1..8)
ADDR_WIDTH, 32, width of START/END window registers (8..DATA_WIDTH)
DATA_WIDTH, 32, APB pwdata/prdata width
PADDR_WIDTH, 12, APB address width
WAIT_STATES, 0, access-phase cycles with pready low before completion (0..3)

Ports:
pclock  input  1  APB clock
presetn  input  1  asynchronous active-low reset
psel  input  1  slave select
penable  input  1  access phase
pwrite  input  1  1=write, 0=read
paddr  input  PADDR_WIDTH  byte address
pwdata  input  DATA_WIDTH  write data
prdata  output  DATA_WIDTH  read data, valid while pready=1
pready  output  1  transfer completion
pslverr  output  1  error response, valid while pready=1
start_addr  output  NUM_REGIONS*ADDR_WIDTH  region n START at slice [n*ADDR_WIDTH +: ADDR_WIDTH]
end_addr  output  NUM_REGIONS*ADDR_WIDTH  region n END, same slicing
ctrl_reg  output  NUM_REGIONS*2  region n {xor,enable} at [2n+1:2n]
region_cfg_done  output  NUM_REGIONS  region n START, END and CTRL each written at least once
config_b  output  1  AND of all region_cfg_done bits

Behaviour:
- The clock is pclock. Reset is presetn, asynchronous and active-low. All state, outputs and registers reset to 0: prdata, pready, pslverr, start_addr, end_addr, ctrl_reg, lock bits, written flags and the wait counter.
- Register map. Region n base is n*0x10.
  - +0x0 START, R/W.
  - +0x4 END, R/W.
  - +0x8 CTRL, R/W: bit0 enable, bit1 xor, bit2 lock (write-1-to-set only).
  - 0x100 STATUS, RO: [NUM_REGIONS-1:0]=region_cfg_done, [8+NUM_REGIONS-1:8]=lock bits.
  - 0x104 PARAM, RO: [3:0]=NUM_REGIONS, [7:4]=WAIT_STATES.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when psel=1 and penable=0. Wait counter loads WAIT_STATES.
  - In ACCESS, pready=1 when counter==0; otherwise the counter decrements each cycle and pready stays 0.
  - ACCESS -> IDLE on the edge where psel & penable & pready.
  - If psel drops during ACCESS, the transfer is aborted: return to IDLE, no register update, pready=0.
- pready and pslverr are registered and high for exactly one cycle per transfer. They are 0 in IDLE.
- Writes commit on the clock edge that ends the pready=1 cycle. Register outputs change on that edge.
- START/END take pwdata[ADDR_WIDTH-1:0]; upper bits are ignored. CTRL takes pwdata[1:0]; the lock bit is set if pwdata[2]=1.
- Reads: prdata is registered and holds the addressed value (zero-extended) during the pready=1 cycle. It is 0 in all other cycles and on error.
- pslverr=1, with no state change, for any of the following:
  - paddr[1:0]!=0 (unaligned);
  - unmapped address, including region index >= NUM_REGIONS;
  - write to STATUS or PARAM;
  - write to any register of a locked region.
- Lock clears only on presetn. A write that sets lock also updates enable/xor in the same transfer.
- The written flag for a register sets only on a successful write. region_cfg_done[n] = all three flags for region n.
- Back-to-back transfers are supported: a new setup phase may immediately follow a completion.
- Asynchronous reset mid-transfer forces IDLE immediately. The partial write is discarded.

Test Plan:
- Reset, then read 0x104 with WAIT_STATES=2 -> pready low 2 access cycles, then prdata=0x24, pslverr=0; all outputs 0 after reset.
- Write region 1: START=0x1000, END=0x1FFF, CTRL=0x3 -> start_addr slice1=0x1000, end_addr slice1=0x1FFF, ctrl_reg[3:2]=2'b11, region_cfg_done=4'b0010, config_b=0; reading back returns the same values.
- Configure all 4 regions -> config_b rises on the edge completing the final write; STATUS read returns 0x0000000F.
- Write CTRL region 0 = 0x5, then START region 0 = 0xABCD -> second transfer pslverr=1, start_addr slice0 unchanged; STATUS[8]=1.
- Accesses to 0x042 (unaligned), 0x040 (region 4 absent), and a write to 0x100 -> pslverr=1 each, prdata=0, no register or flag change.
- Assert presetn low during the access phase of a write of 0x55 to 0x10 -> no update, all outputs 0; the next read of 0x10 after reset release returns 0.
